// File: rtl/wormhole_out_ctrl_pkg.sv
// Shared flit codes, port indices and state encodings
// for the mesh router output-port controller.
package wormhole_out_ctrl_pkg;

  localparam int NP = 5;

  localparam logic [2:0] FID_HEADER = 3'b001;
  localparam logic [2:0] FID_BODY   = 3'b010;
  localparam logic [2:0] FID_TAIL   = 3'b100;

  localparam int P_L = 0;
  localparam int P_N = 1;
  localparam int P_E = 2;
  localparam int P_W = 3;
  localparam int P_S = 4;

  localparam logic [NP-1:0] PTR_RST = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_BUSY = 2'b10
  } state_t;

  function automatic logic [2:0] sel_fid(
    input logic [NP-1:0]   oh,
    input logic [3*NP-1:0] bus
  );
    logic [2:0] f;
    f = '0;
    unique case (1'b1)
      oh[P_L]: f = bus[2:0];
      oh[P_N]: f = bus[5:3];
      oh[P_E]: f = bus[8:6];
      oh[P_W]: f = bus[11:9];
      oh[P_S]: f = bus[14:12];
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/wormhole_out_ctrl_rr_pick5.sv
// 5-way rotating-priority picker; the input after ptr
// has top priority, the ptr input itself comes last.
module rr_pick5
  import wormhole_out_ctrl_pkg::*;
(
  input  logic [NP-1:0] req,
  input  logic [NP-1:0] ptr,
  output logic [NP-1:0] winner,
  output logic          any
);

  logic [2:0] pidx;
  logic [3:0] s;

  always_comb begin
    pidx   = 3'(P_S);
    s      = '0;
    winner = '0;
    for (int j = 0; j < NP; j++) begin
      if (ptr[j]) pidx = 3'(j);
    end
    for (int k = 1; k <= NP; k++) begin
      s = {1'b0, pidx} + 4'(k);
      if (s >= 4'(NP)) s = s - 4'(NP);
      if (winner == '0 && req[s[2:0]]) begin
        winner[s[2:0]] = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/wormhole_out_ctrl.sv
// Wormhole output-port controller: round-robin grant, credit
// gating, pop strobes. OUT_CTRL_WATCHDOG_EN adds a stall watchdog.
module wormhole_out_ctrl
  import wormhole_out_ctrl_pkg::*;
#(
  parameter int CREDIT_DEPTH = 4,
  parameter int CW           = 3
`ifdef OUT_CTRL_WATCHDOG_EN
  , parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NP-1:0]   req,
  input  logic [NP-1:0]   flit_valid,
  input  logic [3*NP-1:0] flit_id_bus,
  input  logic            credit_in,
  output logic [NP-1:0]   grant,
  output logic            idle,
  output logic [NP-1:0]   rd_en,
  output logic            wr_out,
  output logic [CW-1:0]   credit_cnt,
  output logic            credit_err
`ifdef OUT_CTRL_WATCHDOG_EN
  , output logic          wd_timeout
`endif
);

  state_t        state;
  state_t        state_n;
  logic [NP-1:0] grant_n;
  logic [NP-1:0] rr_ptr;
  logic [NP-1:0] ptr_n;
  logic [NP-1:0] pick_ptr;
  logic [NP-1:0] winner;
  logic          any;
  logic          busy;
  logic          can_send;
  logic [2:0]    g_fid;
  logic          tail_rel;
  logic          rel;
  logic [CW-1:0] credit_n;
  logic          err_n;

  assign busy     = (state == ST_BUSY);
  assign can_send = busy && (credit_cnt != '0);
  assign rd_en    = can_send ? (grant & flit_valid) : '0;
  assign wr_out   = |rd_en;
  assign g_fid    = sel_fid(grant, flit_id_bus);
  assign tail_rel = wr_out && (g_fid == FID_TAIL);

  // On release the finished input becomes the pointer so it ranks last.
  assign pick_ptr = busy ? grant : rr_ptr;

  rr_pick5 u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .winner (winner),
    .any    (any)
  );

`ifdef OUT_CTRL_WATCHDOG_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SW-1:0] stall_cnt;
  logic          wd_fire;

  assign wd_fire = busy && !wr_out
                && (stall_cnt == SW'(TIMEOUT_CYCLES - 1));
  assign rel     = tail_rel || wd_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      wd_timeout <= 1'b0;
    end else begin
      wd_timeout <= wd_fire;
      if (!busy || wr_out || wd_fire) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + SW'(1);
      end
    end
  end
`else
  assign rel = tail_rel;
`endif

  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n   = rr_ptr;
    unique case (state)
      ST_IDLE: begin
        if (any) begin
          grant_n = winner;
          state_n = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (rel) begin
          ptr_n = grant;
          if (any) begin
            grant_n = winner;
          end else begin
            grant_n = '0;
            state_n = ST_IDLE;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_comb begin
    credit_n = credit_cnt;
    err_n    = credit_err;
    case ({wr_out, credit_in})
      2'b10: credit_n = credit_cnt - CW'(1);
      2'b01: begin
        if (credit_cnt == CW'(CREDIT_DEPTH)) begin
          err_n = 1'b1;
        end else begin
          credit_n = credit_cnt + CW'(1);
        end
      end
      default: credit_n = credit_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      idle       <= 1'b1;
      rr_ptr     <= PTR_RST;
      credit_cnt <= CW'(CREDIT_DEPTH);
      credit_err <= 1'b0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      idle       <= (grant_n == '0);
      rr_ptr     <= ptr_n;
      credit_cnt <= credit_n;
      credit_err <= err_n;
    end
  end

endmodule

// File: tb/tb_wormhole_out_ctrl.sv
// Scoreboard bench for wormhole_out_ctrl: expected flits queued
// at stimulus time, popped and compared as the DUT forwards them.
module tb_wormhole_out_ctrl;
  import wormhole_out_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  req = '0;
  logic [4:0]  flit_valid = '0;
  logic [14:0] flit_id_bus = '0;
  logic        credit_in = 1'b0;
  logic [4:0]  grant;
  logic        idle;
  logic [4:0]  rd_en;
  logic        wr_out;
  logic [2:0]  credit_cnt;
  logic        credit_err;
`ifdef OUT_CTRL_WATCHDOG_EN
  logic        wd_timeout;
`endif

  always #5 clk = ~clk;

  wormhole_out_ctrl #(
    .CREDIT_DEPTH (4),
    .CW           (3)
`ifdef OUT_CTRL_WATCHDOG_EN
    , .TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .flit_valid  (flit_valid),
    .flit_id_bus (flit_id_bus),
    .credit_in   (credit_in),
    .grant       (grant),
    .idle        (idle),
    .rd_en       (rd_en),
    .wr_out      (wr_out),
    .credit_cnt  (credit_cnt),
    .credit_err  (credit_err)
`ifdef OUT_CTRL_WATCHDOG_EN
    , .wd_timeout (wd_timeout)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  logic [2:0] srcq [5][$];
  logic [5:0] sb [$];
  logic [4:0] fire_n = '0;
  logic       auto_credit = 1'b0;
  logic       credit_nxt = 1'b0;
  logic [5:0] mon_e;
  logic [2:0] mon_id;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 5; i++) begin
      flit_valid[i] = (srcq[i].size() != 0);
      flit_id_bus[3*i +: 3] = (srcq[i].size() != 0) ? srcq[i][0] : 3'b0;
    end
  endtask

  task automatic src(input int p, input logic [2:0] id);
    srcq[p].push_back(id);
  endtask

  task automatic expf(input int p, input logic [2:0] id);
    sb.push_back({3'(p), id});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    credit_in = 1'b0;
    auto_credit = 1'b0;
    for (int i = 0; i < 5; i++) srcq[i].delete();
    sb.delete();
    refresh();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: a flit forwarded in this cycle must match the scoreboard head.
  always @(negedge clk) begin
    fire_n = rst ? 5'b0 : rd_en;
    credit_nxt = wr_out && !rst;
    if (wr_out && !rst) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(rd_en), 0);
      end else begin
        mon_e = sb.pop_front();
        mon_id = '0;
        for (int i = 0; i < 5; i++)
          if (rd_en[i]) mon_id = flit_id_bus[3*i +: 3];
        check("rd_en", 32'(rd_en), 32'(5'b1 << mon_e[5:3]));
        check("flit_id", 32'(mon_id), 32'(mon_e[2:0]));
      end
    end
  end

  // Input buffers pop on the edge that transferred their head flit.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 5; i++)
      if (fire_n[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
    if (auto_credit) credit_in = credit_nxt;
    refresh();
  end

  initial begin
    // reset values
    do_reset();
    check("rst_grant", 32'(grant), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_credit", 32'(credit_cnt), 4);
    check("rst_err", 32'(credit_err), 0);

    // single 3-flit packet on N
    src(P_N, FID_HEADER); src(P_N, FID_BODY); src(P_N, FID_TAIL);
    expf(P_N, FID_HEADER); expf(P_N, FID_BODY); expf(P_N, FID_TAIL);
    refresh();
    req = 5'b00010;
    tick();
    check("t1_grant", 32'(grant), 'b00010);
    check("t1_idle", 32'(idle), 0);
    check("t1_rd_en", 32'(rd_en), 'b00010);
    req = '0;
    tick();
    check("t1_credit_mid", 32'(credit_cnt), 3);
    tick();
    tick();
    check("t1_grant_end", 32'(grant), 0);
    check("t1_idle_end", 32'(idle), 1);
    check("t1_credit_end", 32'(credit_cnt), 1);
    check("t1_sb_empty", sb.size(), 0);
    credit_in = 1'b1;
    tick(); tick(); tick();
    credit_in = 1'b0;
    check("t1_credit_back", 32'(credit_cnt), 4);

    // all five inputs requesting, 2-flit packets, round-robin order
    do_reset();
    for (int p = 0; p < 5; p++) begin
      src(p, FID_HEADER); src(p, FID_TAIL);
    end
    src(P_L, FID_HEADER); src(P_L, FID_TAIL);
    for (int p = 0; p < 5; p++) begin
      expf(p, FID_HEADER); expf(p, FID_TAIL);
    end
    expf(P_L, FID_HEADER); expf(P_L, FID_TAIL);
    refresh();
    auto_credit = 1'b1;
    req = 5'b11111;
    tick();
    check("t2_first", 32'(grant), 'b00001);
    for (int c = 0; c < 12; c++) tick();
    check("t2_sb_empty", sb.size(), 0);
    check("t2_next_grant", 32'(grant), 'b00010);
    check("t2_no_idle", 32'(idle), 0);
    auto_credit = 1'b0;
    credit_in = 1'b0;

    // credit starvation on E with a 6-flit packet
    do_reset();
    src(P_E, FID_HEADER);
    for (int b = 0; b < 4; b++) src(P_E, FID_BODY);
    src(P_E, FID_TAIL);
    expf(P_E, FID_HEADER);
    for (int b = 0; b < 4; b++) expf(P_E, FID_BODY);
    expf(P_E, FID_TAIL);
    refresh();
    req = 5'b00100;
    tick();
    check("t3_grant", 32'(grant), 'b00100);
    req = '0;
    for (int c = 0; c < 4; c++) tick();
    check("t3_credit0", 32'(credit_cnt), 0);
    check("t3_sent4", sb.size(), 2);
    tick(); tick();
    check("t3_hold_grant", 32'(grant), 'b00100);
    check("t3_stall_wr", 32'(wr_out), 0);
    check("t3_still4", sb.size(), 2);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    check("t3_credit1", 32'(credit_cnt), 1);
    tick();
    check("t3_sent5", sb.size(), 1);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    tick();
    check("t3_idle", 32'(idle), 1);
    check("t3_sb_empty", sb.size(), 0);
    credit_in = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    credit_in = 1'b0;
    check("t3_credit_back", 32'(credit_cnt), 4);

    // simultaneous credit_in/wr_out, then overflow
    src(P_L, FID_HEADER); src(P_L, FID_BODY);
    src(P_L, FID_BODY); src(P_L, FID_TAIL);
    expf(P_L, FID_HEADER); expf(P_L, FID_BODY);
    expf(P_L, FID_BODY); expf(P_L, FID_TAIL);
    refresh();
    req = 5'b00001;
    tick();
    req = '0;
    tick(); tick();
    check("t4_credit2", 32'(credit_cnt), 2);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    check("t4_both", 32'(credit_cnt), 2);
    tick();
    check("t4_credit1", 32'(credit_cnt), 1);
    check("t4_idle", 32'(idle), 1);
    credit_in = 1'b1;
    tick(); tick(); tick();
    check("t4_full", 32'(credit_cnt), 4);
    check("t4_no_err", 32'(credit_err), 0);
    tick();
    credit_in = 1'b0;
    check("t4_sat", 32'(credit_cnt), 4);
    check("t4_err", 32'(credit_err), 1);
    tick();
    check("t4_err_sticky", 32'(credit_err), 1);

    // reset in the middle of a W packet
    src(P_W, FID_HEADER); src(P_W, FID_BODY);
    src(P_W, FID_BODY); src(P_W, FID_TAIL);
    expf(P_W, FID_HEADER); expf(P_W, FID_BODY);
    refresh();
    req = 5'b01000;
    tick();
    check("t5_grant", 32'(grant), 'b01000);
    req = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("t5_rst_grant", 32'(grant), 0);
    check("t5_rst_idle", 32'(idle), 1);
    check("t5_rst_credit", 32'(credit_cnt), 4);
    check("t5_rst_err", 32'(credit_err), 0);
    check("t5_sent2", sb.size(), 0);
    rst = 1'b0;
    srcq[P_W].delete();
    src(P_L, FID_TAIL);
    src(P_W, FID_HEADER); src(P_W, FID_TAIL);
    expf(P_L, FID_TAIL);
    expf(P_W, FID_HEADER); expf(P_W, FID_TAIL);
    refresh();
    req = 5'b01001;
    tick();
    check("t5_ptr_s", 32'(grant), 'b00001);
    req = 5'b01000;
    tick();
    check("t5_single", 32'(grant), 'b01000);
    check("t5_busy", 32'(idle), 0);
    req = '0;
    tick(); tick();
    check("t5_idle", 32'(idle), 1);
    check("t5_sb_empty", sb.size(), 0);

`ifdef OUT_CTRL_WATCHDOG_EN
    // watchdog releases a starved S grant to pending N
    do_reset();
    src(P_N, FID_TAIL);
    expf(P_N, FID_TAIL);
    refresh();
    req = 5'b10000;
    tick();
    check("wd_grant_s", 32'(grant), 'b10000);
    req = 5'b00010;
    for (int c = 0; c < 7; c++) tick();
    check("wd_quiet", 32'(wd_timeout), 0);
    check("wd_hold", 32'(grant), 'b10000);
    tick();
    check("wd_pulse", 32'(wd_timeout), 1);
    check("wd_grant_n", 32'(grant), 'b00010);
    req = '0;
    tick();
    check("wd_pulse_end", 32'(wd_timeout), 0);
    check("wd_idle", 32'(idle), 1);
    check("wd_sb_empty", sb.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
